// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter -- write-port arbiter for the 32x32 register file.
//
// Two writeback sources (EX, MEM) each feed a DEPTH-entry FIFO. At most one
// queue head is granted per cycle. The granted write is driven onto the
// register-file write port from registered outputs.
//
// Build option: define RF_WB_SCOREBOARD_EN to build the per-register
// pending-write scoreboard (busy_mask). When it is not defined, busy_mask is
// tied to zero.
//
// Ports:
//   clk                      clock, all state updates on posedge
//   reset                    asynchronous, active-low reset
//   ex_valid/ex_ready        EX request handshake
//   ex_rd/ex_data            EX destination register / write data
//   mem_valid/mem_ready      MEM request handshake
//   mem_rd/mem_data          MEM destination register / write data
//   rf_we/rf_a3/rf_wd3       registered register-file write port
//   busy_mask                bit r set while a write to xr is queued or on the port
module rf_wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  output logic [31:0] busy_mask
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {SRC_EX = 1'b0, SRC_MEM = 1'b1} src_e;

  // Index 0 = EX, index 1 = MEM.
  logic [1:0]        in_valid;
  logic [1:0][4:0]   in_rd;
  logic [1:0][31:0]  in_data;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        nonempty;
  logic [1:0]        full;
  logic [1:0][4:0]   head_rd;
  logic [1:0][31:0]  head_data;
`ifdef RF_WB_SCOREBOARD_EN
  logic [1:0][31:0]  busy_q;
`endif

  // Low during reset, high from the first edge after release; gates ready.
  logic run;
  src_e last_grant;
  logic grant_any;
  src_e grant_src;

  assign in_valid = {mem_valid, ex_valid};
  assign in_rd    = {mem_rd, ex_rd};
  assign in_data  = {mem_data, ex_data};

  for (genvar s = 0; s < 2; s++) begin : g_q
    logic [4:0]    slot_rd   [DEPTH];
    logic [31:0]   slot_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   cnt;

    assign nonempty[s]  = (cnt != '0);
    assign full[s]      = (cnt == (PW+1)'(DEPTH));
    // Writes to x0 are accepted but never stored.
    assign push[s]      = in_valid[s] && run && !full[s] && (in_rd[s] != 5'd0);
    assign head_rd[s]   = slot_rd[rd_ptr];
    assign head_data[s] = slot_data[rd_ptr];

    always_ff @(posedge clk) begin
      if (push[s]) begin
        slot_rd[wr_ptr]   <= in_rd[s];
        slot_data[wr_ptr] <= in_data[s];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[s]) wr_ptr <= wr_ptr + PW'(1);
        if (pop[s])  rd_ptr <= rd_ptr + PW'(1);
        if (push[s] && !pop[s])      cnt <= cnt + (PW+1)'(1);
        else if (pop[s] && !push[s]) cnt <= cnt - (PW+1)'(1);
      end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] busy;
    logic [PW-1:0] off;
    always_comb begin
      busy = '0;
      off  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        // Slot i is live when its distance from the read pointer is below the count.
        off = PW'(i) - rd_ptr;
        if ({1'b0, off} < cnt) busy[slot_rd[PW'(i)]] = 1'b1;
      end
    end
    assign busy_q[s] = busy;
`endif
  end

  assign ex_ready  = run && !full[0];
  assign mem_ready = run && !full[1];

  // Same-rd heads go to MEM (older instruction); otherwise alternate.
  always_comb begin
    grant_any = nonempty[0] || nonempty[1];
    grant_src = SRC_EX;
    if (nonempty[0] && nonempty[1]) begin
      if (head_rd[0] == head_rd[1]) grant_src = SRC_MEM;
      else grant_src = (last_grant == SRC_EX) ? SRC_MEM : SRC_EX;
    end else if (nonempty[1]) begin
      grant_src = SRC_MEM;
    end
  end

  assign pop[0] = grant_any && (grant_src == SRC_EX);
  assign pop[1] = grant_any && (grant_src == SRC_MEM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run        <= 1'b0;
      rf_we      <= 1'b0;
      rf_a3      <= '0;
      rf_wd3     <= '0;
      last_grant <= SRC_EX;
    end else begin
      run   <= 1'b1;
      rf_we <= grant_any;
      if (grant_any) begin
        rf_a3      <= (grant_src == SRC_MEM) ? head_rd[1]   : head_rd[0];
        rf_wd3     <= (grant_src == SRC_MEM) ? head_data[1] : head_data[0];
        last_grant <= grant_src;
      end
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  always_comb begin
    busy_mask = busy_q[0] | busy_q[1];
    if (rf_we) busy_mask[rf_a3] = 1'b1;
    busy_mask[0] = 1'b0;
  end
`else
  assign busy_mask = '0;
`endif

endmodule
